// File: rtl/module_id_pkg.sv
// Shared decode constants, imm-type enum, ID/EX record and immediate helper for the decode stage.
package module_id_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, pc: 32'h0, rs1_data: 32'h0, rs2_data: 32'h0,
                                      imm: 32'h0, rd: 5'h0, opcode: OPC_OPIMM, funct3: 3'h0,
                                      funct7b5: 1'b0, illegal: 1'b0};

    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e t);
        logic [31:0] imm;
        imm = 32'h0;
        case (t)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

    function automatic logic opc_supported(input logic [6:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_OPIMM) || (opc == OPC_AUIPC) ||
               (opc == OPC_STORE) || (opc == OPC_OP)    || (opc == OPC_LUI)   ||
               (opc == OPC_BRANCH)|| (opc == OPC_JALR)  || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/module_id_if.sv
// ID/EX operand bus from decode to execute; decode drives it through the master modport.
interface module_id_if;
    logic        idex_valid_o;
    logic [31:0] idex_pc_o;
    logic [31:0] idex_rs1_data_o;
    logic [31:0] idex_rs2_data_o;
    logic [31:0] idex_imm_o;
    logic [4:0]  idex_rd_o;
    logic [6:0]  idex_opcode_o;
    logic [2:0]  idex_funct3_o;
    logic        idex_funct7b5_o;
    logic        illegal_o;

    modport master (output idex_valid_o, idex_pc_o, idex_rs1_data_o, idex_rs2_data_o, idex_imm_o,
                           idex_rd_o, idex_opcode_o, idex_funct3_o, idex_funct7b5_o, illegal_o);
    modport slave  (input  idex_valid_o, idex_pc_o, idex_rs1_data_o, idex_rs2_data_o, idex_imm_o,
                           idex_rd_o, idex_opcode_o, idex_funct3_o, idex_funct7b5_o, illegal_o);
endinterface

// File: rtl/module_id_frag_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired to zero.
// Reads bypass a same-cycle write so decode never sees a stale value.
module frag_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] regs_q [1:31];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= 32'h0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = 32'h0;
        rd2_o = 32'h0;
        if (ra1_i != 5'd0) rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
        if (ra2_i != 5'd0) rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
    end
endmodule

// File: rtl/module_id.sv
// RISC-V decode stage: IF/ID reg, decode, regfile read, ID/EX reg; ID_ILLEGAL_TRAP_EN flags bad opcodes.
// Latency 2 cycles input->idex_*; redirect squashes both regs, hold_ext_i freezes, load-use stalls fetch via hold_o.
module module_id
    import module_id_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'hffffffff
) (
    input  logic        sys_clk,
    input  logic        sys_arst,
    input  logic        start_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_data_i,
    input  logic        flag_JorB_i,
    input  logic        hold_ext_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        hold_o,
    module_id_if.master idex_o
);
    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] ifid_addr_q, ifid_addr_d;
    logic [31:0] ifid_data_q, ifid_data_d;
    idex_t       idex_q, idex_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_used, rs2_used, load_use;
    imm_type_e   imm_type;
    idex_t       dec;

    assign opcode = ifid_data_q[6:0];
    assign rd     = ifid_data_q[11:7];
    assign rs1    = ifid_data_q[19:15];
    assign rs2    = ifid_data_q[24:20];

    frag_regfile u_regfile (
        .clk_i (sys_clk),
        .rst_i (sys_arst),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rs1_data),
        .rd2_o (rs2_data),
        .we_i  (wb_en_i),
        .wa_i  (wb_addr_i),
        .wd_i  (wb_data_i)
    );

    always_comb begin
        imm_type = IMM_R;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_type = IMM_I;
            OPC_STORE:  begin imm_type = IMM_S; rs2_used = 1'b1; end
            OPC_OP:     rs2_used = 1'b1;
            OPC_BRANCH: begin imm_type = IMM_B; rs2_used = 1'b1; end
            OPC_LUI, OPC_AUIPC: begin imm_type = IMM_U; rs1_used = 1'b0; end
            OPC_JAL:    begin imm_type = IMM_J; rs1_used = 1'b0; end
            default:    imm_type = IMM_R;
        endcase
    end

    always_comb begin
        dec = '{valid: 1'b1, pc: ifid_addr_q, rs1_data: rs1_data, rs2_data: rs2_data,
                imm: imm_gen(ifid_data_q, imm_type), rd: rd, opcode: opcode,
                funct3: ifid_data_q[14:12], funct7b5: ifid_data_q[30], illegal: 1'b0};
        if (!opc_supported(opcode)) begin
`ifdef ID_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
            dec.rd      = 5'd0;
`else
            dec = IDEX_BUBBLE;
`endif
        end
        if (!ifid_vld_q) dec = IDEX_BUBBLE;
    end

    assign load_use = idex_q.valid && (idex_q.opcode == OPC_LOAD) && (idex_q.rd != 5'd0) &&
                      (((idex_q.rd == rs1) && rs1_used) || ((idex_q.rd == rs2) && rs2_used)) &&
                      ifid_vld_q;
    // A redirect discards the dependent instruction, so the stall is pointless then.
    assign hold_o = load_use && !flag_JorB_i;

    always_comb begin
        ifid_vld_d  = ifid_vld_q;
        ifid_addr_d = ifid_addr_q;
        ifid_data_d = ifid_data_q;
        idex_d      = idex_q;
        if (flag_JorB_i) begin
            ifid_vld_d  = 1'b0;
            ifid_addr_d = RST_PC;
            ifid_data_d = NOP_INST;
            idex_d      = IDEX_BUBBLE;
        end else if (hold_ext_i) begin
            idex_d = idex_q;
        end else if (load_use) begin
            idex_d = IDEX_BUBBLE;
        end else begin
            idex_d = dec;
            if (start_i) begin
                ifid_vld_d  = 1'b1;
                ifid_addr_d = inst_addr_i;
                ifid_data_d = inst_data_i;
            end else begin
                ifid_vld_d  = 1'b0;
                ifid_addr_d = RST_PC;
                ifid_data_d = NOP_INST;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_arst) begin
        if (sys_arst) begin
            ifid_vld_q  <= 1'b0;
            ifid_addr_q <= RST_PC;
            ifid_data_q <= NOP_INST;
            idex_q      <= IDEX_BUBBLE;
        end else begin
            ifid_vld_q  <= ifid_vld_d;
            ifid_addr_q <= ifid_addr_d;
            ifid_data_q <= ifid_data_d;
            idex_q      <= idex_d;
        end
    end

    assign idex_o.idex_valid_o    = idex_q.valid;
    assign idex_o.idex_pc_o       = idex_q.pc;
    assign idex_o.idex_rs1_data_o = idex_q.rs1_data;
    assign idex_o.idex_rs2_data_o = idex_q.rs2_data;
    assign idex_o.idex_imm_o      = idex_q.imm;
    assign idex_o.idex_rd_o       = idex_q.rd;
    assign idex_o.idex_opcode_o   = idex_q.opcode;
    assign idex_o.idex_funct3_o   = idex_q.funct3;
    assign idex_o.idex_funct7b5_o = idex_q.funct7b5;
    assign idex_o.illegal_o       = idex_q.illegal;
endmodule

// File: tb/tb_module_id.sv
// Bench for the decode stage: table of instructions through a scoreboard, then hazard/flush/hold/reset sequences.
module tb_module_id;
    logic        sys_clk = 1'b0;
    logic        sys_arst;
    logic        start_i, flag_JorB_i, hold_ext_i, wb_en_i;
    logic [31:0] inst_addr_i, inst_data_i, wb_data_i;
    logic [4:0]  wb_addr_i;
    logic        hold_o;

    module_id_if idex_bus ();

    module_id #(.RST_PC(32'hffffffff)) dut (
        .sys_clk     (sys_clk),
        .sys_arst    (sys_arst),
        .start_i     (start_i),
        .inst_addr_i (inst_addr_i),
        .inst_data_i (inst_data_i),
        .flag_JorB_i (flag_JorB_i),
        .hold_ext_i  (hold_ext_i),
        .wb_en_i     (wb_en_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .hold_o      (hold_o),
        .idex_o      (idex_bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] inst;
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] pc;
        int          due;
    } sb_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    sb_t  sbq [$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input logic [31:0] addr, input logic [31:0] data);
        start_i     = 1'b1;
        inst_addr_i = addr;
        inst_data_i = data;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en_i   = en;
        wb_addr_i = a;
        wb_data_i = d;
    endtask

    initial begin
        sb_t e;
        vecs[0] = '{32'h00500093, 1'b1, 5'd1,  32'h00000005, 7'h13, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{32'h402081b3, 1'b1, 5'd3,  32'h00000000, 7'h33, 3'd0, 1'b1, 32'h11111111, 32'h22222222, 1'b0};
        vecs[2] = '{32'h0020a623, 1'b1, 5'd12, 32'h0000000c, 7'h23, 3'd2, 1'b0, 32'h11111111, 32'h22222222, 1'b0};
        vecs[3] = '{32'hfe000ee3, 1'b1, 5'd29, 32'hfffffffc, 7'h63, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0};
        vecs[4] = '{32'h0080006f, 1'b1, 5'd0,  32'h00000008, 7'h6f, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[5] = '{32'h123453b7, 1'b1, 5'd7,  32'h12345000, 7'h37, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[6] = '{32'hfff00213, 1'b1, 5'd4,  32'hffffffff, 7'h13, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0};
        vecs[7] = '{32'h00001417, 1'b1, 5'd8,  32'h00001000, 7'h17, 3'd1, 1'b0, 32'h0, 32'h0, 1'b0};
`ifdef ID_ILLEGAL_TRAP_EN
        vecs[8] = '{32'h0000057f, 1'b1, 5'd0,  32'h00000000, 7'h7f, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1};
`else
        vecs[8] = '{32'h0000057f, 1'b0, 5'd0,  32'h00000000, 7'h13, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0};
`endif
        vecs[9] = '{32'h0000a283, 1'b1, 5'd5,  32'h00000000, 7'h03, 3'd2, 1'b0, 32'h11111111, 32'h0, 1'b0};

        // Reset state
        sys_arst = 1'b1; start_i = 1'b0; flag_JorB_i = 1'b0; hold_ext_i = 1'b0;
        inst_addr_i = 32'h0; inst_data_i = 32'h13;
        wb(1'b0, 5'd0, 32'h0);
        #2;
        chk("rst_valid",   {31'h0, idex_bus.idex_valid_o}, 32'h0);
        chk("rst_opcode",  {25'h0, idex_bus.idex_opcode_o}, 32'h13);
        chk("rst_imm",     idex_bus.idex_imm_o, 32'h0);
        chk("rst_pc",      idex_bus.idex_pc_o, 32'h0);
        chk("rst_rd",      {27'h0, idex_bus.idex_rd_o}, 32'h0);
        chk("rst_illegal", {31'h0, idex_bus.illegal_o}, 32'h0);
        chk("rst_hold",    {31'h0, hold_o}, 32'h0);
        tick(); tick();
        sys_arst = 1'b0;

        // Preload operands while the core is idle
        wb(1'b1, 5'd1, 32'h11111111); tick();
        wb(1'b1, 5'd2, 32'h22222222); tick();
        wb(1'b0, 5'd0, 32'h0);

        // Table through the scoreboard
        for (int i = 0; i < NVEC + 2; i++) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_valid", e.pc >> 2), {31'h0, idex_bus.idex_valid_o}, {31'h0, e.v.vld});
                chk($sformatf("v%0d_illegal", e.pc >> 2), {31'h0, idex_bus.illegal_o}, {31'h0, e.v.ill});
                if (e.v.vld) begin
                    chk($sformatf("v%0d_pc", e.pc >> 2),  idex_bus.idex_pc_o, e.pc);
                    chk($sformatf("v%0d_rd", e.pc >> 2),  {27'h0, idex_bus.idex_rd_o}, {27'h0, e.v.rd});
                    chk($sformatf("v%0d_imm", e.pc >> 2), idex_bus.idex_imm_o, e.v.imm);
                    chk($sformatf("v%0d_opc", e.pc >> 2), {25'h0, idex_bus.idex_opcode_o}, {25'h0, e.v.opc});
                    chk($sformatf("v%0d_f3", e.pc >> 2),  {29'h0, idex_bus.idex_funct3_o}, {29'h0, e.v.f3});
                    chk($sformatf("v%0d_f7b5", e.pc >> 2), {31'h0, idex_bus.idex_funct7b5_o}, {31'h0, e.v.f7});
                    chk($sformatf("v%0d_rs1", e.pc >> 2), idex_bus.idex_rs1_data_o, e.v.rs1d);
                    chk($sformatf("v%0d_rs2", e.pc >> 2), idex_bus.idex_rs2_data_o, e.v.rs2d);
                end
            end
            if (i < NVEC) begin
                feed(32'(i * 4), vecs[i].inst);
                e.v = vecs[i]; e.pc = 32'(i * 4); e.due = cyc + 2;
                sbq.push_back(e);
            end else begin
                feed(32'h0000_0080, 32'h00000013);
            end
            tick();
        end
        if (sbq.size() != 0) begin
            chk("sb_drained", 32'(sbq.size()), 32'h0);
        end

        // Write-through: WB to x2 in the cycle the add sits in IF/ID
        feed(32'h100, 32'h000101b3); tick();
        wb(1'b1, 5'd2, 32'hdeadbeef); feed(32'h104, 32'h13); tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("wt_rs1", idex_bus.idex_rs1_data_o, 32'hdeadbeef);
        chk("wt_rd",  {27'h0, idex_bus.idex_rd_o}, 32'd3);

        // hold_ext freezes both regs while a write commits
        feed(32'h200, 32'h000101b3); tick();
        hold_ext_i = 1'b1; wb(1'b1, 5'd2, 32'hcafef00d); tick();
        chk("hold_pc", idex_bus.idex_pc_o, 32'h104);
        hold_ext_i = 1'b0; wb(1'b0, 5'd0, 32'h0); feed(32'h204, 32'h13); tick();
        chk("hold_release_pc",  idex_bus.idex_pc_o, 32'h200);
        chk("hold_release_rs1", idex_bus.idex_rs1_data_o, 32'hcafef00d);

        // Load-use: lw x5 then add x6,x5,x5
        feed(32'h300, 32'h0000a283); tick();
        feed(32'h304, 32'h00528333); tick();
        chk("lu_hold_on", {31'h0, hold_o}, 32'h1);
        tick();
        chk("lu_hold_off", {31'h0, hold_o}, 32'h0);
        chk("lu_bubble",   {31'h0, idex_bus.idex_valid_o}, 32'h0);
        feed(32'h308, 32'h13); tick();
        chk("lu_add_valid", {31'h0, idex_bus.idex_valid_o}, 32'h1);
        chk("lu_add_pc",    idex_bus.idex_pc_o, 32'h304);
        chk("lu_add_rd",    {27'h0, idex_bus.idex_rd_o}, 32'd6);

        // Flush while load-use is pending
        feed(32'h400, 32'h0000a283); tick();
        feed(32'h404, 32'h00528333); tick();
        flag_JorB_i = 1'b1; #1;
        chk("fl_hold_masked", {31'h0, hold_o}, 32'h0);
        tick();
        flag_JorB_i = 1'b0; feed(32'h500, 32'h13);
        chk("fl_idex_bubble", {31'h0, idex_bus.idex_valid_o}, 32'h0);
        chk("fl_hold_after",  {31'h0, hold_o}, 32'h0);
        tick();
        chk("fl_ifid_bubble", {31'h0, idex_bus.idex_valid_o}, 32'h0);
        tick();
        chk("fl_resume_pc", idex_bus.idex_pc_o, 32'h500);

        // Mid-stream async reset clears pipeline and regfile
        feed(32'h600, 32'h00000093); tick(); tick();
        #2 sys_arst = 1'b1; #1;
        chk("mrst_valid",  {31'h0, idex_bus.idex_valid_o}, 32'h0);
        chk("mrst_opcode", {25'h0, idex_bus.idex_opcode_o}, 32'h13);
        tick();
        sys_arst = 1'b0;
        feed(32'h700, 32'h000101b3); tick(); tick();
        chk("mrst_pc",      idex_bus.idex_pc_o, 32'h700);
        chk("mrst_x2_zero", idex_bus.idex_rs1_data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/module_id.md
# module_id

Instruction-decode stage of the RISC-V core, directly downstream of the fetch stage. It registers each fetched instruction and its address in an IF/ID register and decodes fields and immediates. It reads the 32×32 register file, which it owns, and presents operands through an ID/EX register to the execute stage. It detects load-use hazards, stalls fetch through one bit of the fetch hold vector, and squashes wrong-path instructions on jump/branch redirects.

## Interface
Parameters:
- RST_PC, 32'hffffffff, IF/ID address value after reset or flush (matches fetch reset address)

Ports:
- sys_clk  in  1  clock, all state on rising edge
- sys_arst  in  1  asynchronous, active-high reset
- start_i  in  1  loader-done level from fetch; low = core idle, stage holds bubbles
- inst_addr_i  in  32  fetched instruction address, aligned with inst_data_i
- inst_data_i  in  32  fetched instruction word
- flag_JorB_i  in  1  redirect from execute; squash IF/ID and ID/EX
- hold_ext_i  in  1  downstream stall; freeze IF/ID and ID/EX
- wb_en_i  in  1  register-file write enable
- wb_addr_i  in  5  write register index
- wb_data_i  in  32  write data
- hold_o  in→out  1  load-use stall request to fetch hold vector (combinational)
- idex_valid_o  out  1  ID/EX holds a real instruction
- idex_pc_o  out  32  instruction address
- idex_rs1_data_o / idex_rs2_data_o  out  32  operands
- idex_imm_o  out  32  sign-extended immediate
- idex_rd_o  out  5  destination index
- idex_opcode_o  out  7; idex_funct3_o  out  3; idex_funct7b5_o  out  1
- illegal_o  out  1  ID/EX instruction has an unsupported opcode (see Configuration)

## Operation
- IF/ID register: valid, addr, data. A bubble is valid=0, addr=RST_PC, data=32'h00000013.
- Decode (combinational on IF/ID): opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7b5=inst[30].
- Immediates: I, S, B (bit0=0), U (low 12 = 0), and J (bit0=0). All are sign-extended from inst[31]. R-type gives 0.
- rs1 is used by all types except LUI, AUIPC, and JAL. rs2 is used only by R, S, and B types.
- Register file: x0 reads 0, and writes to x0 are ignored. Write-through applies: if wb_en_i and wb_addr_i==rs (≠0), the read returns wb_data_i in the same cycle.
- Load-use: hold_o = idex_valid_o & (idex_opcode_o==7'h03) & (idex_rd_o≠0) & ((rd==rs1 & rs1 used) | (rd==rs2 & rs2 used)) & IF/ID valid.
- Per-cycle priority: flush > hold_ext_i > load-use > advance.
  - Flush (flag_JorB_i): IF/ID ← bubble; ID/EX ← bubble.
  - hold_ext_i: both registers keep their values; hold_o is still computed.
  - Load-use: IF/ID keeps its value; ID/EX ← bubble.
  - Advance: ID/EX ← decoded IF/ID; IF/ID ← {start_i, inst_addr_i, inst_data_i}.
- start_i low: IF/ID loads a bubble every cycle, and register-file writes are still accepted.

## Timing
- Latency: an instruction is presented at inst_*_i in cycle N, sits in IF/ID in cycle N+1, and appears on idex_* in cycle N+2.
- hold_o is combinational from the current IF/ID and ID/EX contents. Fetch must see it before the same edge.
- Reset (async, immediate):
  - All idex_* outputs: opcode=7'h13, everything else 0. idex_valid_o=0, illegal_o=0.
  - hold_o=0. IF/ID holds a bubble. All 32 registers are 0.
- Reset deasserting mid-stream: the first edge afterwards follows normal rules; no instruction survives.
- Flush and load-use in the same cycle: flush wins, and hold_o is masked to 0.
- A write to a register during hold_ext_i commits, and the held IF/ID re-reads the new value on the next cycle.

## Configuration
- ID_ILLEGAL_TRAP_EN defined:
  - Opcodes outside {03,13,17,23,33,37,63,67,6F} set illegal_o with the instruction.
  - idex_valid_o stays 1 for that instruction, and rd is forced to 0.
- ID_ILLEGAL_TRAP_EN undefined:
  - illegal_o is tied 0.
  - Unsupported opcodes decode as bubbles (valid=0).

## Structure
- A shared package holds:
  - Opcode constants (OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL).
  - NOP_INST = 32'h00000013.
  - The imm-type enum.
- Sub-module: frag_regfile (2 async read ports, 1 sync write port, write-through, x0 hardwired, async reset).

## Test plan
- Reset, then start_i=1 and feed 32'h00500093 (addi x1,x0,5) at addr 0. Two cycles later: idex_valid_o=1, idex_rd_o=1, idex_imm_o=5, idex_pc_o=0.
- Write x2=32'hdeadbeef via WB in the same cycle that IF/ID holds add x3,x2,x0. Expect idex_rs1_data_o=32'hdeadbeef (write-through).
- lw x5,0(x1) followed by add x6,x5,x5:
  - hold_o=1 for exactly one cycle.
  - One bubble is inserted in ID/EX, then the add issues next.
- flag_JorB_i=1 while IF/ID and ID/EX hold valid instructions. The next cycle shows idex_valid_o=0, and hold_o=0 even if a load-use condition was present.
- B-immediate: 32'hfe000ee3 (beq x0,x0,-4) gives idex_imm_o=32'hfffffffc. J-immediate: 32'h0080006f (jal x0,8) gives 32'h00000008.
- Opcode 7'h7f with ID_ILLEGAL_TRAP_EN gives illegal_o=1 and rd=0. Without the macro it gives idex_valid_o=0 and illegal_o=0.
